// File: rtl/nibble_serial_adder.sv
// Digit-serial adder: steps an external 4-bit ripple adder over NIBBLES
// digits, least significant first, and registers {cout,sum} at the end.
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is a request sampled only in IDLE; there is no
  // backpressure. done is a one-cycle strobe and sum/cout are valid from
  // that cycle until the next completion.

  state_t       state, state_nx;
  logic [W-1:0] a_q, b_q, partial_q, partial_nx;
  logic         carry_q;
  logic [2:0]   idx;
  logic         last;

  assign last      = (idx == 3'(NIBBLES - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_nx   = state;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    partial_nx = partial_q;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        add_a   = a_q[4*idx +: 4];
        add_b   = b_q[4*idx +: 4];
        add_cin = carry_q;
        partial_nx[4*idx +: 4] = add_sum;
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      carry_q   <= 1'b0;
      idx       <= 3'd0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          a_q       <= a;
          b_q       <= b;
          carry_q   <= cin;
          idx       <= 3'd0;
          partial_q <= '0;
        end
        RUN: begin
          partial_q <= partial_nx;
          carry_q   <= add_cout;
          idx       <= idx + 3'd1;
          // The final digit goes straight from the adder into the result.
          if (last) begin
            sum  <= partial_nx;
            cout <= add_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
